// File: rtl/pwm_demod.sv
// PWM demodulator: recovers an m-bit duty word from a single-bit pulse stream by counting
// high samples over a 2^W-clock window aligned to a rising edge of the pulse. A line that
// shows no edge for a whole window (or alignment timeout) is reported as stuck.
// W must be >= m so the duty word can be taken from the top bits of the high-time count.
module pwm_demod #(
  parameter int unsigned m = 12,
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pul,
  output logic [m-1:0] mod_out,
  output logic         valid,
  output logic         stuck
);

  typedef enum logic [1:0] {StIdle, StAlign, StMeasure} state_e;

  localparam logic [W-1:0] WinLast = '1;

  state_e       state;
  logic         pul_m;
  logic         pul_s;
  logic         pul_d;
  logic [W-1:0] win_cnt;
  logic [W:0]   hi_cnt;
  logic         saw_edge;

  logic         rise;
  logic         tog;
  logic [W:0]   hi_total;
  logic [m-1:0] duty_word;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pul_m <= 1'b0;
      pul_s <= 1'b0;
      pul_d <= 1'b0;
    end else begin
      pul_m <= pul;
      pul_s <= pul_m;
      pul_d <= pul_s;
    end
  end

  // Edge detect and end-of-window word, including the current cycle's sample.
  always_comb begin
    rise     = pul_s & ~pul_d;
    tog      = pul_s ^ pul_d;
    hi_total = hi_cnt + {{W{1'b0}}, pul_s};
    // hi_total == 2^W only when every sample was high; saturate rather than wrap to zero.
    duty_word = hi_total[W] ? {m{1'b1}} : hi_total[W-1 -: m];
  end

  // Decoder FSM: idle, align to a rising edge (with timeout), then back-to-back windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      win_cnt  <= '0;
      hi_cnt   <= '0;
      saw_edge <= 1'b0;
      mod_out  <= '0;
      valid    <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        // Any window in progress is dropped without a strobe.
        state    <= StIdle;
        win_cnt  <= '0;
        hi_cnt   <= '0;
        saw_edge <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            win_cnt  <= '0;
            hi_cnt   <= '0;
            saw_edge <= 1'b0;
            state    <= StAlign;
          end
          StAlign: begin
            if (rise) begin
              // This cycle is sample 0 of the first window and it is high.
              state    <= StMeasure;
              win_cnt  <= {{(W-1){1'b0}}, 1'b1};
              hi_cnt   <= {{W{1'b0}}, 1'b1};
              saw_edge <= 1'b0;
            end else if (win_cnt == WinLast) begin
              // Alignment timed out: report the static line level.
              mod_out <= {m{pul_s}};
              stuck   <= 1'b1;
              valid   <= 1'b1;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
          StMeasure: begin
            if (win_cnt == WinLast) begin
              mod_out  <= duty_word;
              stuck    <= ~(saw_edge | tog);
              valid    <= 1'b1;
              win_cnt  <= '0;
              hi_cnt   <= '0;
              saw_edge <= 1'b0;
            end else begin
              win_cnt  <= win_cnt + 1'b1;
              hi_cnt   <= hi_total;
              saw_edge <= saw_edge | tog;
            end
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod with m=4, W=6 (64-clock window). Pulse stream comes from a
// simple PWM model: 6-bit phase stepping by 1, high while phase < duty, duty updated only
// when the phase wraps to 0.
module tb_pwm_demod;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pul;
  logic [3:0] mod_out;
  logic       valid;
  logic       stuck;

  int total;
  int bad;
  int cur_step;
  int phase;
  int duty;
  int next_duty;
  int hold_hi;
  int rise_mark;
  int got;
  int prev;
  int vcount;

  pwm_demod #(
    .m(4),
    .W(6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .pul    (pul),
    .mod_out(mod_out),
    .valid  (valid),
    .stuck  (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, then drive the next PWM sample.
  task automatic step();
    logic np;
    @(posedge clk);
    #1;
    cur_step++;
    if (phase == 0) duty = next_duty;
    np = (hold_hi != 0) || (phase < duty);
    if (np && !pul && rise_mark < 0) rise_mark = cur_step;
    pul = np;
    phase = (phase + 1) % 64;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_to_phase(input int p);
    for (int i = 0; i < 64 && phase != p; i++) step();
  endtask

  task automatic wait_valid(input int maxn, output int at);
    at = -1;
    for (int i = 0; i < maxn && at < 0; i++) begin
      step();
      if (valid === 1'b1) at = cur_step;
    end
    if (at < 0) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    total = 0; bad = 0; cur_step = 0;
    phase = 0; duty = 0; next_duty = 0; hold_hi = 0; rise_mark = 0;
    rst_n = 1'b0; en = 1'b0; pul = 1'b0;

    // Reset state
    steps(3);
    chk("rst_mod", int'(mod_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    rst_n = 1'b1;
    steps(2);

    // Line held low: ALIGN timeout after 64 clocks, repeating every 64
    en = 1'b1;
    prev = cur_step;
    wait_valid(200, got);
    chk("lo_first_lat", got - prev, 65);
    chk("lo_mod", int'(mod_out), 0);
    chk("lo_stuck", int'(stuck), 1);
    step();
    chk("lo_valid_1cyc", int'(valid), 0);
    prev = got;
    wait_valid(200, got);
    chk("lo_period", got - prev, 64);
    chk("lo_stuck2", int'(stuck), 1);

    // Line held high from idle: timeout reports all ones
    en = 1'b0;
    hold_hi = 1;
    steps(5);
    en = 1'b1;
    prev = cur_step;
    wait_valid(200, got);
    chk("hi_first_lat", got - prev, 65);
    chk("hi_mod", int'(mod_out), 15);
    chk("hi_stuck", int'(stuck), 1);

    // Rise then stays high inside MEASURE: 64 highs saturate to 0xF
    en = 1'b0;
    hold_hi = 0;
    steps(5);
    en = 1'b1;
    steps(3);
    rise_mark = -1;
    hold_hi = 1;
    wait_valid(200, got);
    chk("sat_lat", got - rise_mark, 66);
    chk("sat_mod", int'(mod_out), 15);
    chk("sat_stuck", int'(stuck), 1);
    prev = got;
    wait_valid(200, got);
    chk("sat_period", got - prev, 64);
    chk("sat_mod2", int'(mod_out), 15);

    // Duty 20/64 -> word 5
    en = 1'b0;
    hold_hi = 0;
    duty = 20;
    next_duty = 20;
    step_to_phase(32);
    rise_mark = -1;
    en = 1'b1;
    wait_valid(200, got);
    chk("m5_lat", got - rise_mark, 66);
    chk("m5_mod", int'(mod_out), 5);
    chk("m5_stuck", int'(stuck), 0);
    step();
    chk("m5_valid_1cyc", int'(valid), 0);
    prev = got;
    wait_valid(200, got);
    chk("m5_period", got - prev, 64);
    chk("m5_mod2", int'(mod_out), 5);

    // Switch to duty 48/64 on a period boundary: 5 once more, then 12, nothing in between
    next_duty = 48;
    prev = got;
    wait_valid(200, got);
    chk("sw_period1", got - prev, 64);
    chk("sw_mod_old", int'(mod_out), 5);
    chk("sw_stuck1", int'(stuck), 0);
    prev = got;
    wait_valid(200, got);
    chk("sw_period2", got - prev, 64);
    chk("sw_mod_new", int'(mod_out), 12);
    chk("sw_stuck2", int'(stuck), 0);

    // Drop en mid-window: no strobe, output holds; re-enable realigns
    steps(30);
    en = 1'b0;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (valid === 1'b1) vcount++;
    end
    chk("dis_no_valid", vcount, 0);
    chk("dis_mod_hold", int'(mod_out), 12);
    step_to_phase(32);
    rise_mark = -1;
    en = 1'b1;
    wait_valid(200, got);
    chk("reen_lat", got - rise_mark, 66);
    chk("reen_mod", int'(mod_out), 12);
    chk("reen_stuck", int'(stuck), 0);

    // Async reset between clock edges mid-window
    steps(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mod", int'(mod_out), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_stuck", int'(stuck), 0);
    steps(3);
    rst_n = 1'b1;
    wait_valid(250, got);
    chk("post_rst_mod", int'(mod_out), 12);
    chk("post_rst_stuck", int'(stuck), 0);
    prev = got;
    wait_valid(200, got);
    chk("post_rst_period", got - prev, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_demod.md
Name: pwm_demod

Overview:
- PWM decoder: recovers an m-bit modulation word from a single-bit PWM pulse stream.
- The stream comes from the DDS PWM output path, either looped back for self-test or from an external pin.
- Measures high-time over a fixed window of 2^W clocks, aligned to a rising edge of the pulse.
- Publishes the scaled duty word with a one-cycle valid strobe, and flags a stuck line.

Parameters:
- m, 12, output word width (matches the modulator's waveform width).
- W, 14, log2 of measurement window in clocks; W >= m required.

Ports:
- clk      input   1   system clock.
- rst_n    input   1   asynchronous, active-low reset.
- en       input   1   decoder enable.
- pul      input   1   incoming PWM pulse; may be asynchronous to clk.
- mod_out  output  m   decoded duty word (registered).
- valid    output  1   one-cycle strobe: mod_out/stuck updated this cycle.
- stuck    output  1   registered: last window/timeout saw no edge on pul.

Behaviour:
- Reset (async, rst_n=0): sync flops, edge flop, counters, mod_out=0, valid=0, stuck=0, state=IDLE.
- Input path: pul -> 2-flop synchronizer -> pul_s; pul_d = pul_s delayed 1 clk.
  - rise = pul_s & ~pul_d; edge = pul_s ^ pul_d.
  - Input-to-pul_s latency: 2 clks.
- Counters: win_cnt (W bits), hi_cnt (W+1 bits), saw_edge flag.
- State IDLE:
  - Counters cleared; valid=0; mod_out and stuck hold.
  - en=1 -> ALIGN.
- State ALIGN:
  - win_cnt counts timeout cycles.
  - On rise: -> MEASURE. This cycle is window sample 0: win_cnt<=1, hi_cnt<=1, saw_edge<=0.
  - Timeout (win_cnt==2^W-1, no rise): mod_out <= {m{pul_s}}, stuck<=1, valid<=1; stay ALIGN, win_cnt<=0.
- State MEASURE (continuous back-to-back windows):
  - Each cycle: hi_cnt += pul_s; saw_edge |= edge; win_cnt++.
  - Window end at win_cnt==2^W-1, including that cycle's sample:
    - hi_total = hi_cnt + pul_s, range 0..2^W.
    - mod_out <= (hi_total==2^W) ? {m{1}} : hi_total[W-1:W-m] (truncate, saturate).
    - stuck <= ~(saw_edge | edge); valid <= 1 for exactly one cycle.
    - Next window starts next cycle: win_cnt=0, hi_cnt=0, saw_edge=0. No re-alignment.
- valid is registered: asserted the clk after the final sample of a window.
- en=0 in any state: -> IDLE next clk, window in progress discarded, no valid.
- en re-asserted: always restarts from ALIGN.
- rst_n asserted mid-window: immediate clear per reset list; no valid.
- Arithmetic: unsigned throughout; win_cnt wraps naturally at 2^W.
- Simultaneous rise and timeout in ALIGN: rise wins (-> MEASURE, no valid).

Test Plan (m=4, W=6, 64-clk window; stimulus from the DDS PWM modulator with a 6-bit phase stepping by 1, period 64 clks):
- mod=5: pulse high 20/64 clks -> after alignment, valid every 64 clks, mod_out=4'd5, stuck=0.
- mod=0 (pul held low after reset, en=1) -> after 64 clks in ALIGN: valid, mod_out=0, stuck=1; repeats every 64 clks.
- pul held high -> ALIGN timeout: mod_out=4'hF, stuck=1. Pulse rising then staying high inside MEASURE -> hi_total=64 saturates to 4'hF, stuck=1.
- mod=5 then 12 on a period boundary -> mod_out shows 5, then 12 on the next valid; no intermediate value, stuck stays 0.
- en dropped at win_cnt=30 -> no valid, mod_out holds prior value. en re-raised -> realigns, first valid 64 clks after the next rise.
- rst_n pulsed low mid-window (async, between clk edges) -> mod_out/valid/stuck read 0 immediately. After release with en=1 -> normal decode resumes.
